// File: rtl/uart_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// uart_tx_scheduler_if
//
// Purpose:
//   Bundles the request side (requesters -> scheduler) and the transmit side
//   (scheduler <-> UART TX core) handshake signals of uart_tx_scheduler.
//
// Parameters:
//   NUM_REQ  number of requesters
//   DATA_W   byte width per request
//
// Signals:
//   req       per-requester send request (level, held until granted)
//   req_data  packed request bytes, requester i at [i*DATA_W +: DATA_W]
//   grant     one-hot single-cycle acknowledge back to the requesters
//   tx_start  single-cycle start pulse to the TX core
//   tx_data   byte presented to the TX core
//   tx_busy   busy indication from the TX core
//
// Modports:
//   master  scheduler side
//   slave   environment side (requesters plus TX core)
// ----------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
) ();

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        grant;
   logic                      tx_start;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_busy;

   modport master (
      input  req,
      input  req_data,
      input  tx_busy,
      output grant,
      output tx_start,
      output tx_data
   );

   modport slave (
      output req,
      output req_data,
      output tx_busy,
      input  grant,
      input  tx_start,
      input  tx_data
   );

endinterface

// File: rtl/uart_tx_scheduler.sv
// ----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Purpose:
//   Shares one UART transmitter between NUM_REQ byte requesters. Each frame is
//   sequenced as: arbitrate/grant, start pulse, wait for tx_busy to rise, wait
//   for tx_busy to fall, then an enforced inter-frame gap. Baud-select changes
//   are only applied while the scheduler is idle.
//
// Configuration macro:
//   UART_SCHED_FIXED_PRIO_EN  when defined, arbitration is fixed priority
//                             (lowest asserted index wins); when undefined,
//                             arbitration is round-robin starting after the
//                             last granted requester.
//
// Parameters:
//   NUM_REQ     number of requesters (2..8)
//   DATA_W      byte width per request
//   GAP_CYCLES  idle clocks enforced between frames (>=1)
//   BUSY_TO     clocks allowed for tx_busy to rise after tx_start
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   uart_en       UART enable; 0 performs a synchronous soft clear
//   tx_en         transmit enable; gates new arbitrations only
//   baud_sel_req  requested baud select
//   bus           handshake bundle (master modport): req, req_data, tx_busy
//                 in; grant, tx_start, tx_data out
//   baud_sel      applied baud select
//   active_id     index of the last granted requester
//   sched_busy    high in every state except IDLE
//   timeout_flag  sticky; set when tx_busy fails to rise in time
//   frame_cnt     count of completed frames (wraps)
// ----------------------------------------------------------------------------
module uart_tx_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 16,
   parameter int BUSY_TO    = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       uart_en,
   input  logic                       tx_en,
   input  logic [1:0]                 baud_sel_req,
   uart_tx_scheduler_if.master        bus,
   output logic [1:0]                 baud_sel,
   output logic [$clog2(NUM_REQ)-1:0] active_id,
   output logic                       sched_busy,
   output logic                       timeout_flag,
   output logic [15:0]                frame_cnt
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int TO_W  = $clog2(BUSY_TO + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   // Resetting to the highest index makes requester 0 the first one served.
   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TO - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_START,
      S_WAIT_HI,
      S_WAIT_LO,
      S_GAP
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic                tx_start_q, tx_start_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic [1:0]          baud_sel_q, baud_sel_d;
   logic [ID_W-1:0]     active_id_q, active_id_d;
   logic                sched_busy_q, sched_busy_d;
   logic                timeout_flag_q, timeout_flag_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

   logic                win_found;
   logic [ID_W-1:0]     win_id;

   // Arbiter: picks the requester to be granted when the FSM sits in ARB.
`ifdef UART_SCHED_FIXED_PRIO_EN
   // Fixed priority: scanning downwards leaves the lowest asserted index.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req[ID_W'(i)]) begin
            win_found = 1'b1;
            win_id    = ID_W'(i);
         end
      end
   end
`else
   // Round-robin: candidates are visited from active_id+1 upwards, wrapping
   // at NUM_REQ, so the last winner is the lowest priority next time.
   int cand;
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(active_id_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!win_found && bus.req[ID_W'(cand)]) begin
            win_found = 1'b1;
            win_id    = ID_W'(cand);
         end
      end
   end
`endif

   // Next-state and next-output computation for the frame sequencer.
   // grant and tx_start default low so each is a single-cycle pulse.
   always_comb begin
      state_d        = state_q;
      grant_d        = '0;
      tx_start_d     = 1'b0;
      tx_data_d      = tx_data_q;
      baud_sel_d     = baud_sel_q;
      active_id_d    = active_id_q;
      timeout_flag_d = timeout_flag_q;
      frame_cnt_d    = frame_cnt_q;
      to_cnt_d       = to_cnt_q;
      gap_cnt_d      = gap_cnt_q;

      if (!uart_en) begin
         // Soft clear: baud_sel and tx_data deliberately keep their values.
         state_d        = S_IDLE;
         active_id_d    = LAST_ID;
         timeout_flag_d = 1'b0;
         frame_cnt_d    = '0;
         to_cnt_d       = '0;
         gap_cnt_d      = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               // A pending baud change takes the whole cycle; arbitration
               // waits until the applied select matches the request.
               if (baud_sel_req != baud_sel_q) begin
                  baud_sel_d = baud_sel_req;
               end else if (tx_en && (|bus.req)) begin
                  state_d = S_ARB;
               end
            end

            S_ARB: begin
               if (win_found) begin
                  for (int i = 0; i < NUM_REQ; i++) begin
                     grant_d[i] = (ID_W'(i) == win_id);
                  end
                  tx_data_d   = bus.req_data[int'(win_id)*DATA_W +: DATA_W];
                  active_id_d = win_id;
                  state_d     = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end

            S_START: begin
               tx_start_d = 1'b1;
               to_cnt_d   = '0;
               state_d    = S_WAIT_HI;
            end

            S_WAIT_HI: begin
               if (bus.tx_busy) begin
                  state_d = S_WAIT_LO;
               end else begin
                  to_cnt_d = to_cnt_q + 1'b1;
                  if (to_cnt_q == TO_LAST) begin
                     timeout_flag_d = 1'b1;
                     state_d        = S_IDLE;
                  end
               end
            end

            S_WAIT_LO: begin
               if (!bus.tx_busy) begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  gap_cnt_d   = '0;
                  state_d     = S_GAP;
               end
            end

            S_GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_d = S_IDLE;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Registered from the next state so it lines up with state_q.
      sched_busy_d = (state_d != S_IDLE);
   end

   // State and registered-output flops; reset is asynchronous, active low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         grant_q        <= '0;
         tx_start_q     <= 1'b0;
         tx_data_q      <= '0;
         baud_sel_q     <= 2'b00;
         active_id_q    <= LAST_ID;
         sched_busy_q   <= 1'b0;
         timeout_flag_q <= 1'b0;
         frame_cnt_q    <= '0;
         to_cnt_q       <= '0;
         gap_cnt_q      <= '0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         tx_start_q     <= tx_start_d;
         tx_data_q      <= tx_data_d;
         baud_sel_q     <= baud_sel_d;
         active_id_q    <= active_id_d;
         sched_busy_q   <= sched_busy_d;
         timeout_flag_q <= timeout_flag_d;
         frame_cnt_q    <= frame_cnt_d;
         to_cnt_q       <= to_cnt_d;
         gap_cnt_q      <= gap_cnt_d;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign baud_sel     = baud_sel_q;
   assign active_id    = active_id_q;
   assign sched_busy   = sched_busy_q;
   assign timeout_flag = timeout_flag_q;
   assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Purpose:
//   Directed self-checking bench for uart_tx_scheduler with default
//   parameters. A small TX-core model raises tx_busy one clock after it sees
//   tx_start and holds it for busy_len clocks. Honours the
//   UART_SCHED_FIXED_PRIO_EN macro when computing expected grant order.
// ----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

   localparam int NUM_REQ    = 4;
   localparam int DATA_W     = 8;
   localparam int GAP_CYCLES = 16;
   localparam int BUSY_TO    = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        uart_en;
   logic        tx_en;
   logic [1:0]  baud_sel_req;
   logic [1:0]  baud_sel;
   logic [1:0]  active_id;
   logic        sched_busy;
   logic        timeout_flag;
   logic [15:0] frame_cnt;

   logic        model_en;
   int          busy_len;
   int          tests  = 0;
   int          failed = 0;

   uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

   uart_tx_scheduler #(
      .NUM_REQ    (NUM_REQ),
      .DATA_W     (DATA_W),
      .GAP_CYCLES (GAP_CYCLES),
      .BUSY_TO    (BUSY_TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .uart_en      (uart_en),
      .tx_en        (tx_en),
      .baud_sel_req (baud_sel_req),
      .bus          (bus),
      .baud_sel     (baud_sel),
      .active_id    (active_id),
      .sched_busy   (sched_busy),
      .timeout_flag (timeout_flag),
      .frame_cnt    (frame_cnt)
   );

   always #5 clk = ~clk;

   // TX core model: busy rises after the clock that sees tx_start.
   initial begin
      bus.tx_busy = 1'b0;
      forever begin
         @(posedge clk);
         if (model_en === 1'b1 && bus.tx_start === 1'b1) begin
            #1 bus.tx_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 bus.tx_busy = 1'b0;
         end
      end
   end

   // Hang guard.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.grant == '0 && n < 50);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (sched_busy && n < 200);
   endtask

   // Leaves the DUT in WAIT_LO (busy seen high, then one more clock).
   task automatic wait_tx_busy();
      int n;
      n = 0;
      while (bus.tx_busy !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      tick();
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      uart_en      = 1'b0;
      tx_en        = 1'b0;
      baud_sel_req = 2'b00;
      bus.req      = '0;
      bus.req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
      model_en     = 1'b1;
      busy_len     = 10;
      repeat (3) tick();
      tests++; if (bus.grant !== 4'b0000) begin failed++; $display("[TB] FAIL reset_grant: got %b expected 0000", bus.grant); end
      tests++; if (bus.tx_start !== 1'b0) begin failed++; $display("[TB] FAIL reset_tx_start: got %b expected 0", bus.tx_start); end
      tests++; if (bus.tx_data !== 8'h00) begin failed++; $display("[TB] FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
      tests++; if (baud_sel !== 2'b00) begin failed++; $display("[TB] FAIL reset_baud_sel: got %b expected 00", baud_sel); end
      tests++; if (active_id !== 2'd3) begin failed++; $display("[TB] FAIL reset_active_id: got %0d expected 3", active_id); end
      tests++; if (sched_busy !== 1'b0) begin failed++; $display("[TB] FAIL reset_sched_busy: got %b expected 0", sched_busy); end
      tests++; if (timeout_flag !== 1'b0) begin failed++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout_flag); end
      tests++; if (frame_cnt !== 16'd0) begin failed++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
      rst_n   = 1'b1;
      uart_en = 1'b1;
      tx_en   = 1'b1;
      tick();
   endtask

   task automatic test_single_frame();
      int n;
      bus.req = 4'b0001;
      tick();
      tests++; if (bus.grant !== 4'b0000) begin failed++; $display("[TB] FAIL single_early_grant: got %b expected 0000", bus.grant); end
      tests++; if (sched_busy !== 1'b1) begin failed++; $display("[TB] FAIL single_arb_busy: got %b expected 1", sched_busy); end
      tick();
      tests++; if (bus.grant !== 4'b0001) begin failed++; $display("[TB] FAIL single_grant: got %b expected 0001", bus.grant); end
      tests++; if (bus.tx_data !== 8'hA5) begin failed++; $display("[TB] FAIL single_tx_data: got %h expected a5", bus.tx_data); end
      tests++; if (active_id !== 2'd0) begin failed++; $display("[TB] FAIL single_active_id: got %0d expected 0", active_id); end
      tests++; if (bus.tx_start !== 1'b0) begin failed++; $display("[TB] FAIL single_start_early: got %b expected 0", bus.tx_start); end
      bus.req = 4'b0000;
      tick();
      tests++; if (bus.tx_start !== 1'b1) begin failed++; $display("[TB] FAIL single_tx_start: got %b expected 1", bus.tx_start); end
      tests++; if (bus.grant !== 4'b0000) begin failed++; $display("[TB] FAIL single_grant_pulse: got %b expected 0000", bus.grant); end
      tick();
      tests++; if (bus.tx_start !== 1'b0) begin failed++; $display("[TB] FAIL single_start_pulse: got %b expected 0", bus.tx_start); end
      n = 0;
      while (frame_cnt !== 16'd1 && n < 100) begin
         tick();
         n++;
      end
      tests++; if (frame_cnt !== 16'd1) begin failed++; $display("[TB] FAIL single_frame_cnt: got %0d expected 1", frame_cnt); end
      tests++; if (bus.tx_data !== 8'hA5) begin failed++; $display("[TB] FAIL single_tx_data_hold: got %h expected a5", bus.tx_data); end
      wait_idle(n);
      tests++; if (n !== GAP_CYCLES) begin failed++; $display("[TB] FAIL single_gap_len: got %0d expected %0d", n, GAP_CYCLES); end
   endtask

   task automatic test_round_robin();
      int n;
      int exp_id;
      logic [3:0] exp_grant;
      logic [7:0] exp_byte;
      uart_en = 1'b0;
      tick();
      tests++; if (active_id !== 2'd3) begin failed++; $display("[TB] FAIL clear_active_id: got %0d expected 3", active_id); end
      tests++; if (frame_cnt !== 16'd0) begin failed++; $display("[TB] FAIL clear_frame_cnt: got %0d expected 0", frame_cnt); end
      uart_en      = 1'b1;
      bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      bus.req      = 4'b1111;
      for (int k = 0; k < 8; k++) begin
`ifdef UART_SCHED_FIXED_PRIO_EN
         exp_id = 0;
`else
         exp_id = k % NUM_REQ;
`endif
         exp_grant = 4'b0001 << exp_id;
         exp_byte  = 8'(8'h11 * (exp_id + 1));
         wait_grant(n);
         tests++; if (bus.grant !== exp_grant) begin failed++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", k, bus.grant, exp_grant); end
         tests++; if (active_id !== 2'(exp_id)) begin failed++; $display("[TB] FAIL rr_active_id[%0d]: got %0d expected %0d", k, active_id, exp_id); end
         tests++; if (bus.tx_data !== exp_byte) begin failed++; $display("[TB] FAIL rr_tx_data[%0d]: got %h expected %h", k, bus.tx_data, exp_byte); end
         wait_idle(n);
         tests++; if (sched_busy !== 1'b0) begin failed++; $display("[TB] FAIL rr_frame_end[%0d]: got busy %b expected 0", k, sched_busy); end
      end
      bus.req = 4'b0000;
      tests++; if (frame_cnt !== 16'd8) begin failed++; $display("[TB] FAIL rr_frame_cnt: got %0d expected 8", frame_cnt); end
   endtask

   task automatic test_baud_deferred();
      int n;
      int bad;
      bus.req = 4'b0010;
      wait_grant(n);
      tests++; if (bus.grant !== 4'b0010) begin failed++; $display("[TB] FAIL baud_grant1: got %b expected 0010", bus.grant); end
      bus.req = 4'b0000;
      wait_tx_busy();
      baud_sel_req = 2'b11;
      bus.req      = 4'b0010;
      bad = 0;
      n   = 0;
      do begin
         tick();
         n++;
         if (sched_busy && baud_sel !== 2'b00) bad++;
      end while (sched_busy && n < 200);
      tests++; if (bad !== 0) begin failed++; $display("[TB] FAIL baud_early_apply: got %0d bad cycles expected 0", bad); end
      tests++; if (sched_busy !== 1'b0) begin failed++; $display("[TB] FAIL baud_frame_end: got busy %b expected 0", sched_busy); end
      tests++; if (baud_sel !== 2'b00) begin failed++; $display("[TB] FAIL baud_first_idle: got %b expected 00", baud_sel); end
      tick();
      tests++; if (baud_sel !== 2'b11) begin failed++; $display("[TB] FAIL baud_applied: got %b expected 11", baud_sel); end
      tests++; if (bus.grant !== 4'b0000) begin failed++; $display("[TB] FAIL baud_no_grant: got %b expected 0000", bus.grant); end
      tests++; if (sched_busy !== 1'b0) begin failed++; $display("[TB] FAIL baud_idle_hold: got %b expected 0", sched_busy); end
      tick();
      tests++; if (sched_busy !== 1'b1) begin failed++; $display("[TB] FAIL baud_then_arb: got %b expected 1", sched_busy); end
      tick();
      tests++; if (bus.grant !== 4'b0010) begin failed++; $display("[TB] FAIL baud_grant2: got %b expected 0010", bus.grant); end
      bus.req = 4'b0000;
      wait_idle(n);
      tests++; if (frame_cnt !== 16'd10) begin failed++; $display("[TB] FAIL baud_frame_cnt: got %0d expected 10", frame_cnt); end
   endtask

   task automatic test_timeout();
      int n;
      model_en = 1'b0;
      bus.req  = 4'b0001;
      wait_grant(n);
      tests++; if (bus.grant !== 4'b0001) begin failed++; $display("[TB] FAIL to_grant: got %b expected 0001", bus.grant); end
      bus.req = 4'b0000;
      tick();
      tests++; if (bus.tx_start !== 1'b1) begin failed++; $display("[TB] FAIL to_tx_start: got %b expected 1", bus.tx_start); end
      n = 0;
      while (timeout_flag !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      tests++; if (n !== BUSY_TO) begin failed++; $display("[TB] FAIL to_latency: got %0d expected %0d", n, BUSY_TO); end
      tests++; if (sched_busy !== 1'b0) begin failed++; $display("[TB] FAIL to_idle: got %b expected 0", sched_busy); end
      tests++; if (frame_cnt !== 16'd10) begin failed++; $display("[TB] FAIL to_frame_cnt: got %0d expected 10", frame_cnt); end
      uart_en      = 1'b0;
      baud_sel_req = 2'b01;
      tick();
      tick();
      tests++; if (timeout_flag !== 1'b0) begin failed++; $display("[TB] FAIL clr_timeout: got %b expected 0", timeout_flag); end
      tests++; if (frame_cnt !== 16'd0) begin failed++; $display("[TB] FAIL clr_frame_cnt: got %0d expected 0", frame_cnt); end
      tests++; if (active_id !== 2'd3) begin failed++; $display("[TB] FAIL clr_active_id: got %0d expected 3", active_id); end
      tests++; if (baud_sel !== 2'b11) begin failed++; $display("[TB] FAIL clr_baud_kept: got %b expected 11", baud_sel); end
      tests++; if (bus.tx_data !== 8'h11) begin failed++; $display("[TB] FAIL clr_tx_data_kept: got %h expected 11", bus.tx_data); end
      baud_sel_req = 2'b11;
      uart_en      = 1'b1;
      model_en     = 1'b1;
      tick();
   endtask

   task automatic test_tx_en_drop();
      int n;
      int bad;
      bus.req = 4'b0010;
      wait_grant(n);
      tests++; if (bus.grant !== 4'b0010) begin failed++; $display("[TB] FAIL txen_grant1: got %b expected 0010", bus.grant); end
      wait_tx_busy();
      tx_en = 1'b0;
      wait_idle(n);
      tests++; if (sched_busy !== 1'b0) begin failed++; $display("[TB] FAIL txen_frame_end: got busy %b expected 0", sched_busy); end
      tests++; if (frame_cnt !== 16'd1) begin failed++; $display("[TB] FAIL txen_frame_cnt: got %0d expected 1", frame_cnt); end
      bad = 0;
      repeat (30) begin
         tick();
         if (bus.grant !== 4'b0000 || sched_busy !== 1'b0) bad++;
      end
      tests++; if (bad !== 0) begin failed++; $display("[TB] FAIL txen_no_arb: got %0d active cycles expected 0", bad); end
      tx_en = 1'b1;
      wait_grant(n);
      tests++; if (bus.grant !== 4'b0010) begin failed++; $display("[TB] FAIL txen_grant2: got %b expected 0010", bus.grant); end
      bus.req = 4'b0000;
      wait_idle(n);
      tests++; if (frame_cnt !== 16'd2) begin failed++; $display("[TB] FAIL txen_frame_cnt2: got %0d expected 2", frame_cnt); end
   endtask

   task automatic test_reset_mid_frame();
      int n;
      int bad;
      bus.req = 4'b0001;
      wait_grant(n);
      tests++; if (bus.grant !== 4'b0001) begin failed++; $display("[TB] FAIL rst_grant1: got %b expected 0001", bus.grant); end
      bus.req = 4'b0000;
      wait_tx_busy();
      tests++; if (sched_busy !== 1'b1) begin failed++; $display("[TB] FAIL rst_in_frame: got %b expected 1", sched_busy); end
      #3;
      rst_n        = 1'b0;
      baud_sel_req = 2'b00;
      #1;
      tests++; if (baud_sel !== 2'b00) begin failed++; $display("[TB] FAIL rst_baud: got %b expected 00", baud_sel); end
      tests++; if (frame_cnt !== 16'd0) begin failed++; $display("[TB] FAIL rst_frame_cnt: got %0d expected 0", frame_cnt); end
      tests++; if (sched_busy !== 1'b0) begin failed++; $display("[TB] FAIL rst_sched_busy: got %b expected 0", sched_busy); end
      tests++; if (active_id !== 2'd3) begin failed++; $display("[TB] FAIL rst_active_id: got %0d expected 3", active_id); end
      tests++; if (bus.tx_data !== 8'h00) begin failed++; $display("[TB] FAIL rst_tx_data: got %h expected 00", bus.tx_data); end
      #2;
      rst_n = 1'b1;
      bad = 0;
      repeat (30) begin
         tick();
         if (bus.tx_start !== 1'b0 || sched_busy !== 1'b0) bad++;
      end
      tests++; if (bad !== 0) begin failed++; $display("[TB] FAIL rst_no_start: got %0d active cycles expected 0", bad); end
      bus.req = 4'b0100;
      wait_grant(n);
      tests++; if (bus.grant !== 4'b0100) begin failed++; $display("[TB] FAIL rst_grant2: got %b expected 0100", bus.grant); end
      tests++; if (bus.tx_data !== 8'h33) begin failed++; $display("[TB] FAIL rst_tx_data2: got %h expected 33", bus.tx_data); end
      bus.req = 4'b0000;
      wait_idle(n);
      tests++; if (frame_cnt !== 16'd1) begin failed++; $display("[TB] FAIL rst_frame_cnt2: got %0d expected 1", frame_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_round_robin();
      test_baud_deferred();
      test_timeout();
      test_tx_en_drop();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
